// File: rtl/fine_channelizer_pkg.sv
// Shared types and widths for the fine channelizer multiplier path.
package fine_channelizer_pkg;

  localparam int unsigned MUL_IN_W  = 16;
  localparam int unsigned MUL_OUT_W = 32;
  localparam int unsigned MUL_LAT   = 2;
  localparam int unsigned TAG_ID_W  = 4;

  // Requester tag carried alongside each operand pair through the multiplier.
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } mul_tag_t;

endpackage

// File: rtl/fine_channelizer_mul_core.sv
// Two-register signed multiplier (operand regs then product reg), shaped to map
// onto a single DSP48 with AREG/BREG/PREG.
module fine_channelizer_mul_core
  import fine_channelizer_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ce,
  input  logic signed [MUL_IN_W-1:0]  a,
  input  logic signed [MUL_IN_W-1:0]  b,
  output logic signed [MUL_OUT_W-1:0] p
);

  logic signed [MUL_IN_W-1:0]  a_r;
  logic signed [MUL_IN_W-1:0]  b_r;
  logic signed [MUL_OUT_W-1:0] p_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_r <= '0;
      b_r <= '0;
      p_r <= '0;
    end else if (ce) begin
      a_r <= a;
      b_r <= b;
      p_r <= a_r * b_r;
    end
  end

  assign p = p_r;

endmodule

// File: rtl/fine_channelizer_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined signed multiplier among NUM_REQ
// requesters; results return tagged with the owner's index.
module fine_channelizer_mul_arbiter
  import fine_channelizer_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ce,
  input  logic [NUM_REQ-1:0]            req_mask,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [MUL_IN_W*NUM_REQ-1:0]   req_a,
  input  logic [MUL_IN_W*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]            res_valid,
  output logic [ID_W-1:0]               res_id,
  output logic [MUL_OUT_W-1:0]          res_p,
  output logic                          busy
);

  // First eligible index at or after ptr, wrapping; MSB of result is "found".
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                            input logic [ID_W-1:0]    ptr);
    logic            found;
    logic [ID_W-1:0] win;
    logic [ID_W:0]   s;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      s = {1'b0, ptr} + (ID_W+1)'(k);
      if (s >= (ID_W+1)'(NUM_REQ)) s = s - (ID_W+1)'(NUM_REQ);
      if (!found && elig[s[ID_W-1:0]]) begin
        found = 1'b1;
        win   = s[ID_W-1:0];
      end
    end
    return {found, win};
  endfunction

  logic [NUM_REQ-1:0][MUL_IN_W-1:0] a_arr;
  logic [NUM_REQ-1:0][MUL_IN_W-1:0] b_arr;
  logic [ID_W-1:0]                  rr_ptr;
  logic [ID_W-1:0]                  rr_ptr_nxt;
  logic [ID_W:0]                    pick;
  logic                             found;
  logic [ID_W-1:0]                  win;
  logic                             hs;
  mul_tag_t                         tag_q [MUL_LAT];
  mul_tag_t                         s2_tag;
  logic signed [MUL_OUT_W-1:0]      prod;
  logic [NUM_REQ-1:0]               res_valid_d;

  assign a_arr = req_a;
  assign b_arr = req_b;

  // Grant selection and pointer advance.
  always_comb begin
    req_ready  = '0;
    hs         = 1'b0;
    pick       = rr_pick(req_valid & req_mask, rr_ptr);
    found      = pick[ID_W];
    win        = pick[ID_W-1:0];
    rr_ptr_nxt = rr_ptr;
    if (ce && !reset && found) begin
      req_ready  = NUM_REQ'(1) << win;
      hs         = 1'b1;
      rr_ptr_nxt = (win == ID_W'(NUM_REQ-1)) ? '0 : win + ID_W'(1);
    end
  end

  fine_channelizer_mul_core u_mul (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .a     (a_arr[win]),
    .b     (b_arr[win]),
    .p     (prod)
  );

  assign s2_tag = tag_q[MUL_LAT-1];

  // Result strobe and busy derived from the tag pipeline.
  always_comb begin
    res_valid_d = '0;
    busy        = 1'b0;
    if (s2_tag.valid) res_valid_d = NUM_REQ'(1) << s2_tag.id;
    for (int unsigned i = 0; i < MUL_LAT; i++) busy = busy | tag_q[i].valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      res_valid <= '0;
      res_id    <= '0;
      res_p     <= '0;
      for (int unsigned i = 0; i < MUL_LAT; i++) tag_q[i] <= '0;
    end else if (ce) begin
      rr_ptr   <= rr_ptr_nxt;
      tag_q[0] <= '{valid: hs, id: TAG_ID_W'(win)};
      for (int unsigned i = 1; i < MUL_LAT; i++) tag_q[i] <= tag_q[i-1];
      res_valid <= res_valid_d;
      // Id and product hold the last delivered result between strobes.
      if (s2_tag.valid) begin
        res_id <= ID_W'(s2_tag.id);
        res_p  <= prod;
      end
    end
  end

endmodule
